noise_test_gen: RTL and testbench
=================================

Name: noise_test_gen

Overview:
- Self-test stimulus source for the tracking-engine noise floor path.
- Produces the downsampled I/Q sample stream and chip-shift strobe that the noise floor calculator consumes.
- Samples are ±amplitude modulated by the same 10-bit m-sequence (x^10+x^3+1, seed all ones), so a correlating receiver accumulates a known coherent value, plus optional LFSR noise.
- Drives data_down_en / i_data_down / q_data_down / shift_code directly; started and stopped by firmware-controlled register strobes.

Parameters:
- SAMPLE_DIV_W, 8, width of sample_div (clock cycles between samples, minus 1)
- CHIP_DIV_W, 4, width of chip_div (samples per chip, minus 1)

Ports:
- clk  input  1  system clock
- rst  input  1  reset; synchronous, active-high
- start  input  1  one-cycle strobe; begin generation (IDLE only)
- stop  input  1  one-cycle strobe; abort generation
- sample_div  input  SAMPLE_DIV_W  cycles between samples minus 1, latched at start
- chip_div  input  CHIP_DIV_W  samples per chip minus 1, latched at start
- epoch_num  input  8  epochs to generate; 0 = run until stop; latched at start
- amp_i  input  5  unsigned I signal amplitude 0..31, latched at start
- amp_q  input  5  unsigned Q signal amplitude 0..31, latched at start
- noise_en  input  1  add LFSR noise, latched at start
- data_down_en  output  1  sample valid strobe
- i_data_down  output  6  signed I sample
- q_data_down  output  6  signed Q sample
- shift_code  output  1  chip advance strobe
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse on normal completion
- epoch_cnt  output  8  completed epochs in current run

Behaviour:
- All outputs are registered. Reset values: every output 0; PRN = 10'h3FF; noise LFSR = 16'hACE1; state IDLE.
- State machine: IDLE, RUN.
- Priority: rst > stop > start.
- IDLE + start:
  - Latch configuration.
  - Set PRN = 3FF, LFSR = ACE1, div/chip counters and epoch_cnt = 0.
  - Enter RUN; busy goes high the next cycle.
- RUN + start: ignored.
- RUN + stop:
  - Next cycle go to IDLE; busy = 0; data_down_en, shift_code and I/Q = 0.
  - No done pulse; epoch_cnt holds its value.
- IDLE + stop: no effect.
- Sample timing:
  - First data_down_en is asserted on the first cycle in RUN.
  - Thereafter data_down_en is asserted every sample_div+1 cycles, exactly one cycle wide.
  - I/Q are valid only while data_down_en = 1 and are 0 otherwise.
- Sample value:
  - sign = PRN[9], using the pre-shift value.
  - s_i = sign ? -amp_i : +amp_i; s_q likewise with amp_q.
  - If noise_en: add LFSR[3:0] to I and LFSR[7:4] to Q, each as signed 4-bit (-8..7).
  - Compute at 7 bits, then saturate to [-31, +31]. -32 is never output, so the receiver's negation cannot overflow.
- Noise LFSR: Galois, x^16+x^14+x^13+x^11+1; advances once per emitted sample, regardless of noise_en.
- Chip timing:
  - Sample counter counts 0..chip_div.
  - shift_code is asserted coincident with the data_down_en of the last sample of each chip.
  - The internal PRN shifts on that same cycle: {prn[8:0], prn[9]^prn[2]}. This mirrors the receiver exactly.
- Epoch:
  - An epoch ends on the shift for which the next PRN value equals 3FF (1023 chips).
  - On that shift epoch_cnt increments; it wraps 255->0 when epoch_num = 0.
  - If epoch_num != 0 and epoch_cnt+1 == epoch_num: done pulses the cycle after the final sample, state returns to IDLE, busy drops the same cycle as done.
- Reset mid-run: immediate return to reset values on the next clk edge. No done.

Test Plan:
- sample_div=0, chip_div=0, amp_i=10, amp_q=0, noise_en=0, epoch_num=1, start:
  - 1023 consecutive data_down_en and 1023 shift_code pulses.
  - First 10 samples I=-10, sample 11 I=+10, Q=0 throughout.
  - done exactly one cycle after sample 1023, epoch_cnt=1.
  - Sum of PRN-despread I = 10230.
- sample_div=3, chip_div=1, epoch_num=2:
  - data_down_en every 4 cycles; shift_code on every 2nd sample.
  - 4092 samples total, done after epoch 2, epoch_cnt=2.
- amp_i=amp_q=31, noise_en=1, epoch_num=1:
  - No sample equals -32; samples clamp at ±31.
  - LFSR sequence from ACE1 matches the reference model.
- epoch_num=0, stop after 3000 samples:
  - Outputs 0 the cycle after stop; no done; epoch_cnt=2; busy=0.
- start pulsed again while busy:
  - No restart; sample and PRN sequences continue unchanged.
- rst asserted mid-epoch, then start:
  - All outputs 0 after reset.
  - Sequence restarts from PRN 3FF with first I = -amp_i.

Source files
------------

// File: rtl/noise_test_gen.sv
// noise_test_gen: self-test I/Q sample and chip-shift source for the noise floor path
module noise_test_gen #(
  parameter int SAMPLE_DIV_W = 8,
  parameter int CHIP_DIV_W   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    stop,
  input  logic [SAMPLE_DIV_W-1:0] sample_div,
  input  logic [CHIP_DIV_W-1:0]   chip_div,
  input  logic [7:0]              epoch_num,
  input  logic [4:0]              amp_i,
  input  logic [4:0]              amp_q,
  input  logic                    noise_en,
  output logic                    data_down_en,
  output logic [5:0]              i_data_down,
  output logic [5:0]              q_data_down,
  output logic                    shift_code,
  output logic                    busy,
  output logic                    done,
  output logic [7:0]              epoch_cnt
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;
  logic [SAMPLE_DIV_W-1:0] sdiv, sdiv_nx, div_cnt, div_cnt_nx;
  logic [CHIP_DIV_W-1:0] cdiv, cdiv_nx, chip_cnt, chip_cnt_nx, cur_chip, cur_cdiv;
  logic [7:0] ep_lim, ep_lim_nx, epoch_cnt_nx, ep_base, ep_inc, cur_lim;
  logic [4:0] ai, ai_nx, aq, aq_nx, cur_ai, cur_aq;
  logic nen, nen_nx, cur_nen, fin, fin_nx;
  logic [9:0] prn, prn_nx, cur_prn, prn_sh;
  logic [15:0] lfsr, lfsr_nx, cur_lfsr;
  logic dde_nx, shift_nx, busy_nx, done_nx, launch, emit, last_chip, epoch_end;
  logic [5:0] i_nx, q_nx;
  logic signed [6:0] si, sq, ni, nq;
  function automatic logic [5:0] sat(input logic signed [6:0] v);
    return v > 7'sd31 ? 6'd31 : v < -7'sd31 ? 6'h21 : v[5:0];
  endfunction
  function automatic logic [15:0] lfsr_adv(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction
  // A launch emits the first sample on the same edge, so it works from the fresh inputs and seeds.
  always_comb begin
    launch = state == IDLE && start && !stop;
    emit = launch || (state == RUN && !stop && !fin && div_cnt == sdiv);
    cur_prn = launch ? 10'h3FF : prn;
    cur_lfsr = launch ? 16'hACE1 : lfsr;
    cur_chip = launch ? '0 : chip_cnt;
    cur_cdiv = launch ? chip_div : cdiv;
    cur_ai = launch ? amp_i : ai;
    cur_aq = launch ? amp_q : aq;
    cur_nen = launch ? noise_en : nen;
    cur_lim = launch ? epoch_num : ep_lim;
    ep_base = launch ? 8'd0 : epoch_cnt;
    ep_inc = ep_base + 8'd1;
    last_chip = cur_chip == cur_cdiv;
    prn_sh = {cur_prn[8:0], cur_prn[9] ^ cur_prn[2]};
    epoch_end = emit && last_chip && prn_sh == 10'h3FF;
    si = cur_prn[9] ? -$signed({2'b00, cur_ai}) : $signed({2'b00, cur_ai});
    sq = cur_prn[9] ? -$signed({2'b00, cur_aq}) : $signed({2'b00, cur_aq});
    ni = cur_nen ? $signed({{3{cur_lfsr[3]}}, cur_lfsr[3:0]}) : 7'sd0;
    nq = cur_nen ? $signed({{3{cur_lfsr[7]}}, cur_lfsr[7:4]}) : 7'sd0;
    state_nx = state;
    sdiv_nx = launch ? sample_div : sdiv;
    cdiv_nx = cur_cdiv;
    ep_lim_nx = cur_lim;
    ai_nx = cur_ai;
    aq_nx = cur_aq;
    nen_nx = cur_nen;
    div_cnt_nx = launch ? '0 : div_cnt;
    chip_cnt_nx = cur_chip;
    prn_nx = cur_prn;
    lfsr_nx = cur_lfsr;
    epoch_cnt_nx = ep_base;
    fin_nx = launch ? 1'b0 : fin;
    dde_nx = 1'b0;
    shift_nx = 1'b0;
    i_nx = '0;
    q_nx = '0;
    done_nx = 1'b0;
    if (launch) state_nx = RUN;
    if (state == RUN) begin
      if (stop) state_nx = IDLE;
      else if (fin) begin
        state_nx = IDLE;
        done_nx = 1'b1;
      end else div_cnt_nx = div_cnt == sdiv ? '0 : div_cnt + 1'b1;
    end
    if (emit) begin
      dde_nx = 1'b1;
      i_nx = sat(si + ni);
      q_nx = sat(sq + nq);
      shift_nx = last_chip;
      chip_cnt_nx = last_chip ? '0 : cur_chip + 1'b1;
      prn_nx = last_chip ? prn_sh : cur_prn;
      lfsr_nx = lfsr_adv(cur_lfsr);
      epoch_cnt_nx = epoch_end ? ep_inc : ep_base;
      fin_nx = epoch_end && cur_lim != 8'd0 && ep_inc == cur_lim;
    end
    busy_nx = state_nx == RUN;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sdiv <= '0;
      cdiv <= '0;
      ep_lim <= '0;
      ai <= '0;
      aq <= '0;
      nen <= 1'b0;
      div_cnt <= '0;
      chip_cnt <= '0;
      prn <= 10'h3FF;
      lfsr <= 16'hACE1;
      fin <= 1'b0;
      epoch_cnt <= '0;
      data_down_en <= 1'b0;
      i_data_down <= '0;
      q_data_down <= '0;
      shift_code <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_nx;
      sdiv <= sdiv_nx;
      cdiv <= cdiv_nx;
      ep_lim <= ep_lim_nx;
      ai <= ai_nx;
      aq <= aq_nx;
      nen <= nen_nx;
      div_cnt <= div_cnt_nx;
      chip_cnt <= chip_cnt_nx;
      prn <= prn_nx;
      lfsr <= lfsr_nx;
      fin <= fin_nx;
      epoch_cnt <= epoch_cnt_nx;
      data_down_en <= dde_nx;
      i_data_down <= i_nx;
      q_data_down <= q_nx;
      shift_code <= shift_nx;
      busy <= busy_nx;
      done <= done_nx;
    end
  end
endmodule

// File: tb/tb_noise_test_gen.sv
// tb_noise_test_gen: directed checks of noise_test_gen against a reference PRN/LFSR model
module tb_noise_test_gen;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0, noise_en = 1'b0;
  logic [7:0] sample_div = '0, epoch_num = '0, epoch_cnt;
  logic [3:0] chip_div = '0;
  logic [4:0] amp_i = '0, amp_q = '0;
  logic data_down_en, shift_code, busy, done;
  logic [5:0] i_data_down, q_data_down;
  int tests = 0, fails = 0;
  int cyc = 0, last_cyc = 0, done_cyc = 0;
  int n_samp, n_shift, n_done, samp_err, gap_err, zero_err, neg32, n_clamp, desp;
  int m_sdiv, m_cdiv, m_ai, m_aq, chip_m, g;
  logic m_nen;
  logic [9:0] prn_m;
  logic [15:0] lfsr_m;
  int first_i [16];

  noise_test_gen dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .sample_div(sample_div),
    .chip_div(chip_div), .epoch_num(epoch_num), .amp_i(amp_i), .amp_q(amp_q),
    .noise_en(noise_en), .data_down_en(data_down_en), .i_data_down(i_data_down),
    .q_data_down(q_data_down), .shift_code(shift_code), .busy(busy), .done(done),
    .epoch_cnt(epoch_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sat_m(input int v);
    return v > 31 ? 31 : v < -31 ? -31 : v;
  endfunction

  task automatic tick();
    int gi, gq, ni, nq;
    logic signed [3:0] t;
    @(negedge clk);
    cyc++;
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (!data_down_en) begin
      if (i_data_down != 6'd0 || q_data_down != 6'd0 || shift_code) zero_err++;
    end else begin
      gi = int'($signed(i_data_down));
      gq = int'($signed(q_data_down));
      t = lfsr_m[3:0];
      ni = m_nen ? int'(t) : 0;
      t = lfsr_m[7:4];
      nq = m_nen ? int'(t) : 0;
      if (gi != sat_m((prn_m[9] ? -m_ai : m_ai) + ni)) samp_err++;
      if (gq != sat_m((prn_m[9] ? -m_aq : m_aq) + nq)) samp_err++;
      if (gi == -32 || gq == -32) neg32++;
      if (gi == 31 || gi == -31 || gq == 31 || gq == -31) n_clamp++;
      if (n_samp > 0 && cyc - last_cyc != m_sdiv + 1) gap_err++;
      if (n_samp < 16) first_i[n_samp] = gi;
      desp += prn_m[9] ? -gi : gi;
      if (shift_code != (chip_m == m_cdiv)) samp_err++;
      if (chip_m == m_cdiv) begin
        prn_m = {prn_m[8:0], prn_m[9] ^ prn_m[2]};
        chip_m = 0;
        n_shift++;
      end else chip_m++;
      lfsr_m = {1'b0, lfsr_m[15:1]} ^ (lfsr_m[0] ? 16'hB400 : 16'h0000);
      n_samp++;
      last_cyc = cyc;
    end
  endtask

  task automatic start_run(input int sd, input int cd, input int en, input int ai, input int aq, input logic ne);
    sample_div = 8'(sd);
    chip_div = 4'(cd);
    epoch_num = 8'(en);
    amp_i = 5'(ai);
    amp_q = 5'(aq);
    noise_en = ne;
    m_sdiv = sd; m_cdiv = cd; m_ai = ai; m_aq = aq; m_nen = ne;
    prn_m = 10'h3FF; lfsr_m = 16'hACE1; chip_m = 0;
    n_samp = 0; n_shift = 0; n_done = 0; samp_err = 0; gap_err = 0;
    zero_err = 0; neg32 = 0; n_clamp = 0; desp = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_to_done(input int limit);
    g = 0;
    while (n_done == 0 && g < limit) begin
      tick();
      g++;
    end
    for (int k = 0; k < 3; k++) tick();
  endtask

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_dde", data_down_en, 0);
    chk("rst_i", i_data_down, 0);
    chk("rst_q", q_data_down, 0);
    chk("rst_shift", shift_code, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_epoch", epoch_cnt, 0);

    start_run(0, 0, 1, 10, 0, 1'b0);
    chk("t1_busy_first", busy, 1);
    chk("t1_dde_first", data_down_en, 1);
    run_to_done(1100);
    chk("t1_samples", n_samp, 1023);
    chk("t1_shifts", n_shift, 1023);
    chk("t1_i10", first_i[9], -10);
    chk("t1_i11", first_i[10], 10);
    chk("t1_samp_err", samp_err, 0);
    chk("t1_gap_err", gap_err, 0);
    chk("t1_done_cnt", n_done, 1);
    chk("t1_done_lat", done_cyc - last_cyc, 1);
    chk("t1_epoch", epoch_cnt, 1);
    chk("t1_busy_end", busy, 0);
    chk("t1_despread", desp, 10230);

    start_run(3, 1, 2, 5, 7, 1'b0);
    run_to_done(17000);
    chk("t2_samples", n_samp, 4092);
    chk("t2_shifts", n_shift, 2046);
    chk("t2_samp_err", samp_err, 0);
    chk("t2_gap_err", gap_err, 0);
    chk("t2_done_cnt", n_done, 1);
    chk("t2_epoch", epoch_cnt, 2);

    start_run(0, 0, 1, 31, 31, 1'b1);
    run_to_done(1100);
    chk("t3_samp_err", samp_err, 0);
    chk("t3_neg32", neg32, 0);
    chk("t3_clamped", int'(n_clamp > 0), 1);
    chk("t3_samples", n_samp, 1023);

    start_run(0, 0, 0, 9, 4, 1'b0);
    g = 0;
    while (n_samp < 3000 && g < 4000) begin
      tick();
      g++;
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t4_dde", data_down_en, 0);
    chk("t4_i", i_data_down, 0);
    chk("t4_busy", busy, 0);
    chk("t4_epoch", epoch_cnt, 2);
    repeat (5) tick();
    chk("t4_no_done", n_done, 0);
    chk("t4_samples", n_samp, 3000);
    chk("t4_samp_err", samp_err, 0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t4_idle_stop", epoch_cnt, 2);

    start_run(1, 0, 0, 7, 2, 1'b0);
    g = 0;
    while (n_samp < 20 && g < 100) begin
      tick();
      g++;
    end
    amp_i = 5'd3;
    sample_div = 8'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    g = 0;
    while (n_samp < 60 && g < 200) begin
      tick();
      g++;
    end
    chk("t5_samples", n_samp, 60);
    chk("t5_samp_err", samp_err, 0);
    chk("t5_gap_err", gap_err, 0);
    stop = 1'b1;
    tick();
    stop = 1'b0;

    start_run(0, 0, 0, 12, 6, 1'b0);
    g = 0;
    while (n_samp < 100 && g < 200) begin
      tick();
      g++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_dde", data_down_en, 0);
    chk("t6_i", i_data_down, 0);
    chk("t6_q", q_data_down, 0);
    chk("t6_shift", shift_code, 0);
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_epoch", epoch_cnt, 0);
    start_run(0, 0, 0, 12, 6, 1'b0);
    repeat (30) tick();
    chk("t6_first_i", first_i[0], -12);
    chk("t6_samp_err", samp_err, 0);
    chk("t6_zero_err", zero_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
